// File: rtl/board_ram_arbiter.sv
// Round-robin, burst-locked arbiter sharing the single-port board RAM among game-logic engines.
// The owner keeps the port until it drops req; one dead cycle separates consecutive owners.
module board_ram_arbiter #(
  parameter int unsigned N_REQ  = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr_bus,
  input  logic [N_REQ*DATA_W-1:0]   wdata_bus,
  input  logic [N_REQ-1:0]          wren,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]         rd_q,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_q,
  output logic                      busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   rdv_q [RD_LAT];

  logic               pick_vld_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [IDX_W-1:0]   scan_idx_c;
  logic [N_REQ-1:0]   issue_c;

  // Round-robin pick: scan downward so the lowest offset after last_q wins.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_idx_c = '0;
    scan_idx_c = '0;
    for (int k = N_REQ; k > 0; k--) begin
      scan_idx_c = IDX_W'((32'(last_q) + 32'(k)) % N_REQ);
      if (req[scan_idx_c]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = scan_idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE, S_RELEASE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
        if (pick_vld_c) begin
          state_d = S_GRANT;
          gnt_d   = N_REQ'(1) << pick_idx_c;
          last_d  = pick_idx_c;
        end
      end
      S_GRANT: begin
        // last_q holds the owner index while granted
        if (!req[last_q]) begin
          state_d = S_RELEASE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  // AND-OR port mux off the one-hot grant; a granted cycle with req low neither writes nor reads.
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    issue_c  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        ram_addr   = ram_addr | addr_bus[i*ADDR_W +: ADDR_W];
        ram_data   = ram_data | wdata_bus[i*DATA_W +: DATA_W];
        ram_wren   = ram_wren | (wren[i] & req[i]);
        issue_c[i] = req[i] & ~wren[i];
      end
    end
  end

  // Read-owner tag pipe, one-hot per stage, aligned to the RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LAT; s++) rdv_q[s] <= '0;
    end else begin
      rdv_q[0] <= issue_c;
      for (int s = 1; s < RD_LAT; s++) rdv_q[s] <= rdv_q[s-1];
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign rd_valid = rdv_q[RD_LAT-1];
  assign rd_q     = ram_q;

endmodule
